// File: rtl/resize_sequencer_pkg.sv
// Shared types and sizing helpers for the resize coordinate sequencer.
package pkg_resize_seq;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DEF_XW          = 10;
  localparam int DEF_YW          = 10;
  localparam int DEF_FW          = 16;
  localparam int DEF_FRAC        = 8;
  localparam int DEF_LANES       = 1;
  localparam int DEF_OUTSTANDING = 4;

  // Wide enough for any coordinate times any factor plus a full lane chain.
  function automatic int acc_width(input int coord_w, input int factor_w, input int lanes);
    return coord_w + factor_w + $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/resize_lane_coord.sv
// Splits one accumulated fixed-point coordinate into integer/fraction and
// clamps the integer part to the last valid source pixel.
module resize_lane_coord #(
  parameter int W    = 10,
  parameter int FRAC = 8,
  parameter int AW   = 27
) (
  input  logic [AW-1:0]   acc,
  input  logic [W-1:0]    img,
  output logic [W-1:0]    coord_int,
  output logic [FRAC-1:0] coord_frac
);

  localparam int IW = AW - FRAC;

  logic [IW-1:0] whole;
  logic [IW-1:0] lim;

  assign whole = acc[AW-1:FRAC];
  // An empty image clamps to 0 instead of wrapping to all-ones.
  assign lim   = (img == '0) ? '0 : (IW'(img) - IW'(1));

  always_comb begin
    coord_int  = whole[W-1:0];
    coord_frac = acc[FRAC-1:0];
    if (whole > lim) begin
      coord_int  = lim[W-1:0];
      coord_frac = '0;
    end
  end

endmodule

// File: rtl/resize_sequencer.sv
// Walks the destination raster LANES pixels per beat, producing clamped
// fixed-point source coordinates under a credit limit.
//
// state   | meaning
// S_IDLE  | waiting for a job, credits held full
// S_RUN   | issuing beats while credits remain
// S_DRAIN | no beats, waiting for every issued beat to be acknowledged
// S_DONE  | status presented until done_taken
module resize_sequencer
  import pkg_resize_seq::*;
#(
  parameter int XW          = DEF_XW,
  parameter int YW          = DEF_YW,
  parameter int FW          = DEF_FW,
  parameter int FRAC        = DEF_FRAC,
  parameter int LANES       = DEF_LANES,
  parameter int OUTSTANDING = DEF_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [XW-1:0]         job_img_x,
  input  logic [YW-1:0]         job_img_y,
  input  logic [XW-1:0]         job_tgt_x,
  input  logic [YW-1:0]         job_tgt_y,
  input  logic [FW-1:0]         job_factor_x,
  input  logic [FW-1:0]         job_factor_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XW-1:0]         out_dx,
  output logic [YW-1:0]         out_dy,
  output logic [LANES*XW-1:0]   out_sx,
  output logic [LANES*FRAC-1:0] out_fx,
  output logic [YW-1:0]         out_sy,
  output logic [FRAC-1:0]       out_fy,
  output logic [LANES-1:0]      out_mask,
  output logic                  out_eol,
  output logic                  out_last,
  input  logic                  beat_ack,
  input  logic                  abort,
  output logic                  done,
  input  logic                  done_taken,
  output logic                  done_aborted,
  output logic                  done_err,
  output logic                  busy
);

  localparam int AXW = acc_width(XW, FW, LANES);
  localparam int AYW = acc_width(YW, FW, 1);
  localparam int CW  = $clog2(OUTSTANDING + 1);
  localparam int DW  = XW + 4;
  localparam logic [CW-1:0] CMAX = CW'(OUTSTANDING);

  state_t         state;
  logic [XW-1:0]  img_x, tgt_x, dx;
  logic [YW-1:0]  img_y, tgt_y, dy;
  logic [FW-1:0]  fac_x, fac_y;
  logic [AXW-1:0] ax;
  logic [AYW-1:0] ay;
  logic [CW-1:0]  credits, credits_nxt;
  logic           aborted, err;
  logic           run, fire, row_end, img_end;
  logic [AXW-1:0] lane_acc [LANES+1];

  assign run     = (state == S_RUN);
  assign fire    = out_valid && out_ready;
  assign row_end = (DW'(dx) + DW'(LANES)) >= DW'(tgt_x);
  assign img_end = row_end && ((dy + YW'(1)) == tgt_y);

  assign job_ready    = (state == S_IDLE) && !reset;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign done_aborted = done && aborted;
  assign done_err     = done && err;
  assign out_valid    = run && (credits != '0);
  assign out_eol      = run && row_end;
  assign out_last     = run && img_end;
  assign out_dx       = dx;
  assign out_dy       = dy;

  // Lane k sits k factor steps past ax; the extra tap is the next beat's ax.
  always_comb begin
    lane_acc[0] = ax;
    for (int k = 0; k < LANES; k++) lane_acc[k+1] = lane_acc[k] + AXW'(fac_x);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    resize_lane_coord #(.W(XW), .FRAC(FRAC), .AW(AXW)) u_col (
      .acc        (lane_acc[k]),
      .img        (img_x),
      .coord_int  (out_sx[k*XW +: XW]),
      .coord_frac (out_fx[k*FRAC +: FRAC])
    );
    assign out_mask[k] = run && ((DW'(dx) + DW'(k)) < DW'(tgt_x));
  end

  resize_lane_coord #(.W(YW), .FRAC(FRAC), .AW(AYW)) u_row (
    .acc        (ay),
    .img        (img_y),
    .coord_int  (out_sy),
    .coord_frac (out_fy)
  );

  always_comb begin
    credits_nxt = credits;
    if (fire && !beat_ack)
      credits_nxt = credits - CW'(1);
    else if (!fire && beat_ack && credits != CMAX)
      credits_nxt = credits + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      img_x   <= '0;
      img_y   <= '0;
      tgt_x   <= '0;
      tgt_y   <= '0;
      fac_x   <= '0;
      fac_y   <= '0;
      dx      <= '0;
      dy      <= '0;
      ax      <= '0;
      ay      <= '0;
      credits <= CMAX;
      aborted <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          credits <= CMAX;
          if (job_valid) begin
            img_x   <= job_img_x;
            img_y   <= job_img_y;
            tgt_x   <= job_tgt_x;
            tgt_y   <= job_tgt_y;
            fac_x   <= job_factor_x;
            fac_y   <= job_factor_y;
            dx      <= '0;
            dy      <= '0;
            ax      <= '0;
            ay      <= '0;
            aborted <= 1'b0;
            if (job_tgt_x == '0 || job_tgt_y == '0) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          credits <= credits_nxt;
          if (fire) begin
            if (row_end) begin
              dx <= '0;
              ax <= '0;
              dy <= dy + YW'(1);
              ay <= ay + AYW'(fac_y);
            end else begin
              dx <= dx + XW'(LANES);
              ax <= lane_acc[LANES];
            end
          end
          if (abort) begin
            aborted <= 1'b1;
            state   <= S_DRAIN;
          end else if (fire && img_end) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          credits <= credits_nxt;
          if (abort) aborted <= 1'b1;
          if (credits_nxt == CMAX) state <= S_DONE;
        end
        S_DONE: begin
          if (done_taken) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  credit_overflow: assert property (@(posedge clk) disable iff (reset)
    ((state == S_RUN || state == S_DRAIN) && beat_ack && !fire) |-> (credits != CMAX));

endmodule
